// File: rtl/if_id_queue.sv
// IF/ID boundary buffer: DEPTH-entry first-word-fall-through queue carrying
// PC, instruction, prediction bit and saved PC from fetch to decode.
module if_id_queue #(
  parameter int INST_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PC_WIDTH-1:0]       in_pc,
  input  logic [INST_WIDTH-1:0]     in_inst,
  input  logic                      in_pred,
  input  logic [PC_WIDTH-1:0]       in_save_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PC_WIDTH-1:0]       out_pc,
  output logic [INST_WIDTH-1:0]     out_inst,
  output logic                      out_pred,
  output logic [PC_WIDTH-1:0]       out_save_pc,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PC_WIDTH-1:0]   pc_q   [DEPTH];
  logic [INST_WIDTH-1:0] inst_q [DEPTH];
  logic                  pred_q [DEPTH];
  logic [PC_WIDTH-1:0]   save_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq, deq;

  // Handshake: a transfer happens on a side only in a cycle where both valid
  // and ready are high at the rising edge. in_ready/out_valid come from the
  // registered count alone, so there is no bypass or full-queue pass-through.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (enq && !deq)      count_d = count_q + CNT_W'(1);
    else if (deq && !enq) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; stale slots are unreachable once count is zero.
  always_ff @(posedge clk) begin
    if (enq && !reset && !flush) begin
      pc_q[wr_ptr_q]   <= in_pc;
      inst_q[wr_ptr_q] <= in_inst;
      pred_q[wr_ptr_q] <= in_pred;
      save_q[wr_ptr_q] <= in_save_pc;
    end
  end

  // An empty queue presents an all-zero bubble to decode.
  always_comb begin
    out_pc      = '0;
    out_inst    = '0;
    out_pred    = 1'b0;
    out_save_pc = '0;
    if (out_valid) begin
      out_pc      = pc_q[rd_ptr_q];
      out_inst    = inst_q[rd_ptr_q];
      out_pred    = pred_q[rd_ptr_q];
      out_save_pc = save_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios plus random traffic, compared
// every cycle against a queue-based reference model.
module tb_if_id_queue;
  localparam int IW    = 32;
  localparam int PW    = 32;
  localparam int DEPTH = 4;
  localparam int EW    = PW + IW + 1 + PW;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, in_pred;
  logic          out_valid, out_ready, out_pred;
  logic [PW-1:0] in_pc, in_save_pc, out_pc, out_save_pc;
  logic [IW-1:0] in_inst, out_inst;
  logic [2:0]    count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  if_id_queue #(.INST_WIDTH(IW), .PC_WIDTH(PW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_pred(in_pred), .in_save_pc(in_save_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_pred(out_pred), .out_save_pc(out_save_pc),
    .count(count)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [PW-1:0] pc, input logic pred,
                       input logic [PW-1:0] save);
    in_valid   = v;
    in_pc      = pc;
    in_inst    = $urandom;
    in_pred    = pred;
    in_save_pc = save;
  endtask

  // Compare outputs mid-cycle, then advance the model across the rising edge.
  task automatic step();
    logic [EW-1:0] head;
    bit accept, pop;
    @(negedge clk);
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("count", 128'(count), 128'(exp_q.size()));
    check("in_ready", 128'(in_ready), 128'(exp_q.size() < DEPTH));
    check("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
    check("out_data", 128'({out_pc, out_inst, out_pred, out_save_pc}), 128'(head));
    @(posedge clk);
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      accept = in_valid && (exp_q.size() < DEPTH);
      pop    = (exp_q.size() > 0) && out_ready;
      if (pop) void'(exp_q.pop_front());
      if (accept) exp_q.push_back({in_pc, in_inst, in_pred, in_save_pc});
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #1;

    // Reset held two cycles with fetch presenting.
    step(); step();
    reset = 1'b0; drive(1'b0, 32'h0, 1'b0, 32'h0);
    step();

    // Stall fill, rejected fifth push, in-order drain.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 32'h0);
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", 128'(out_pc), 128'(32'h100 + 32'(4 * i)));
      step();
    end
    step();

    // Streaming at full rate, wrapping the pointers.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 1'b0, 32'h0);
      step();
      check("stream_pc", 128'(out_pc), 128'(32'h200 + 32'(4 * i)));
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    step(); step();

    // Flush with three buffered entries and fetch presenting.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 1'b1, 32'h400);
      step();
    end
    flush = 1'b1; drive(1'b1, 32'h500, 1'b1, 32'h400);
    step();
    flush = 1'b0; drive(1'b1, 32'h400, 1'b0, 32'h404);
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    check("post_flush_pc", 128'(out_pc), 128'(32'h400));
    out_ready = 1'b1;
    step(); step();

    // Full queue with dequeue and a competing enqueue.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h600 + 32'(4 * i), 1'b0, 32'h0);
      step();
    end
    drive(1'b1, 32'h700, 1'b0, 32'h0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Reset and flush together over two buffered entries.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h800 + 32'(4 * i), 1'b1, 32'h900);
      step();
    end
    reset = 1'b1; flush = 1'b1;
    step();
    reset = 1'b0; flush = 1'b0; drive(1'b0, 32'h0, 1'b0, 32'h0);
    step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)), $urandom);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 1'b0; flush = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
